// File: rtl/wr_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wr_port_arbiter_pkg
// Description : Shared definitions for the register-file write-port arbiter:
//               FSM state encodings and the default hold limit.
// Revision    : 1.0 - initial release
// ============================================================================
package wr_port_arbiter_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int MAX_HOLD_DEFAULT = 8;

endpackage : wr_port_arbiter_pkg
`default_nettype wire

// File: rtl/wr_port_arbiter_decoder.sv
`default_nettype none
// ============================================================================
// Module      : decoder
// Description : Parameterized binary-to-one-hot decoder.
//   Ports     : i_idx    [N_BITS-1:0]    binary index
//               o_onehot [2**N_BITS-1:0] one-hot expansion of i_idx
// Revision    : 1.0 - initial release
// ============================================================================
module decoder #(
  parameter int N_BITS = 2
) (
  input  logic [N_BITS-1:0]      i_idx,
  output logic [2**N_BITS-1:0]   o_onehot
);

  localparam int N = 2**N_BITS;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign o_onehot[gi] = (i_idx == N_BITS'(gi));
  end

endmodule : decoder
`default_nettype wire

// File: rtl/wr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wr_port_arbiter
// Description : Round-robin arbiter for the register-file write port shared
//               by 2**N_BITS requesters. A grant is held until the holder
//               signals done, drops its request, or the hold limit expires;
//               the next holder is granted back-to-back.
//   Ports     : clk        clock, rising edge
//               reset      synchronous active-high reset
//               req        [N-1:0] per-requester level request
//               done       current holder releases this cycle
//               grant      [N-1:0] one-hot grant, zero when idle
//               grant_idx  [N_BITS-1:0] current holder, 0 when idle
//               busy       a grant is active
//               expired    grant is being force-released by the hold limit
// Revision    : 1.0 - initial release
// ============================================================================
module wr_port_arbiter
  import wr_port_arbiter_pkg::*;
#(
  parameter int N_BITS   = 2,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2**N_BITS-1:0]  req,
  input  logic                  done,
  output logic [2**N_BITS-1:0]  grant,
  output logic [N_BITS-1:0]     grant_idx,
  output logic                  busy,
  output logic                  expired
);

  localparam int         N          = 2**N_BITS;
  localparam logic [7:0] C_MAX_HOLD = 8'(MAX_HOLD);

  logic [0:0]        r_state;
  logic [N_BITS-1:0] r_ptr;
  logic [N_BITS-1:0] r_grant_idx;
  logic [7:0]        r_hold_cnt;
  logic              r_expired;

  logic              w_any;
  logic [N_BITS-1:0] w_pick;
  logic              w_release;
  logic [7:0]        w_hold_inc;
  logic [N-1:0]      w_dec;

  assign w_any = |req;

  // Round-robin pick: scan ptr+1 .. ptr+N (mod N, via natural wrap of the
  // index width). Iterating from the farthest offset down to the nearest
  // lets the nearest asserted request overwrite the others, so the current
  // holder (offset N) is considered last.
  always_comb begin
    w_pick = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[r_ptr + N_BITS'(k)]) begin
        w_pick = r_ptr + N_BITS'(k);
      end
    end
  end

  assign w_release  = done || !req[r_grant_idx] || (r_hold_cnt == C_MAX_HOLD);
  assign w_hold_inc = r_hold_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '1;
      r_grant_idx <= '0;
      r_hold_cnt  <= '0;
      r_expired   <= 1'b0;
    end else if (r_state == ST_IDLE || w_release) begin
      if (w_any) begin
        r_state     <= ST_GRANT;
        r_ptr       <= w_pick;
        r_grant_idx <= w_pick;
        r_hold_cnt  <= 8'd1;
        // expired is registered: raise it for the cycle whose count will
        // equal the limit (immediately when the limit is a single cycle).
        r_expired   <= (C_MAX_HOLD == 8'd1);
      end else begin
        r_state     <= ST_IDLE;
        r_grant_idx <= '0;
        r_hold_cnt  <= '0;
        r_expired   <= 1'b0;
      end
    end else begin
      r_hold_cnt <= w_hold_inc;
      r_expired  <= (w_hold_inc == C_MAX_HOLD);
    end
  end

  decoder #(
    .N_BITS   (N_BITS)
  ) u_decoder (
    .i_idx    (r_grant_idx),
    .o_onehot (w_dec)
  );

  assign busy      = (r_state == ST_GRANT);
  assign grant     = w_dec & {N{busy}};
  assign grant_idx = r_grant_idx;
  assign expired   = r_expired;

endmodule : wr_port_arbiter
`default_nettype wire

// File: tb/tb_wr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wr_port_arbiter
// Description : Scoreboard bench for wr_port_arbiter. Stimulus pushes the
//               reference model's expected outputs; a monitor pops and
//               compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_port_arbiter;

  localparam int N_BITS   = 2;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  typedef struct packed {
    logic [N-1:0]      g;
    logic [N_BITS-1:0] idx;
    logic              b;
    logic              e;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic              done = 1'b0;
  logic [N-1:0]      grant;
  logic [N_BITS-1:0] grant_idx;
  logic              busy;
  logic              expired;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit m_busy   = 1'b0;
  int m_holder = 0;
  int m_ptr    = N - 1;
  int m_cnt    = 0;

  always #5 clk = ~clk;

  wr_port_arbiter #(
    .N_BITS   (N_BITS),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .expired   (expired)
  );

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic d, input logic rs);
    bit rel;
    if (rs) begin
      m_busy = 0; m_holder = 0; m_ptr = N - 1; m_cnt = 0;
    end else if (!m_busy) begin
      if (r != 0) begin
        m_holder = pick(r, m_ptr); m_ptr = m_holder; m_cnt = 1; m_busy = 1;
      end
    end else begin
      rel = d || !r[m_holder] || (m_cnt == MAX_HOLD);
      if (rel) begin
        if (r != 0) begin
          m_holder = pick(r, m_ptr); m_ptr = m_holder; m_cnt = 1;
        end else begin
          m_busy = 0; m_holder = 0; m_cnt = 0;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic d, input logic rs);
    exp_t e;
    @(negedge clk);
    req = r; done = d; reset = rs;
    model_step(r, d, rs);
    e.g   = m_busy ? N'(1 << m_holder) : '0;
    e.idx = N_BITS'(m_holder);
    e.b   = m_busy;
    e.e   = m_busy && (m_cnt == MAX_HOLD);
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (grant !== e.g || grant_idx !== e.idx || busy !== e.b || expired !== e.e) begin
          errors++;
          $display("FAIL outputs t=%0t: got grant=%b idx=%0d busy=%b expired=%b, want grant=%b idx=%0d busy=%b expired=%b",
                   $time, grant, grant_idx, busy, expired, e.g, e.idx, e.b, e.e);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [N-1:0] r;
    logic d, rs;
    r = '0;

    // Reset, then idle with no requests
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);
    repeat (5) cycle(4'b0000, 1'b0, 1'b0);

    // All requesting, done every cycle: 0,1,2,3,0,1
    repeat (6) cycle(4'b1111, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);

    // Sole requester held to the limit, then re-granted
    repeat (12) cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);

    // Holder 1 drops while 3 and 0 request: 3 wins
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0011, 1'b0, 1'b0);
    cycle(4'b1001, 1'b0, 1'b0);
    cycle(4'b1001, 1'b0, 1'b0);

    // Reset in the middle of a grant, then fresh arbitration from ptr=3
    cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b1111, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0);

    // done while idle is ignored
    cycle(4'b0000, 1'b0, 1'b1);
    repeat (3) cycle(4'b0000, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) < 4) r = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 99) == 0);
      cycle(r, d, rs);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wr_port_arbiter
`default_nettype wire
